// File: rtl/axon_pkg.sv
// Shared constants and the per-slot record for the axon delay line.
// Counters are stored at MAX_DELAY_W bits; channels use the low DELAY_W bits.
package axon_pkg;

  localparam int CHANNELS_DEF = 4;
  localparam int DELAY_W_DEF  = 6;
  localparam int DEPTH_DEF    = 4;
  localparam int DROP_CNT_W   = 8;
  localparam int MAX_DELAY_W  = 16;

  typedef struct packed {
    logic                   valid;
    logic [MAX_DELAY_W-1:0] counter;
  } slot_t;

endpackage

// File: rtl/axon_channel.sv
// One axon channel: DEPTH independent countdown slots feeding a single
// registered spike output, plus overflow drop pulse and saturating drop count.
module axon_channel
  import axon_pkg::*;
#(
  parameter int DELAY_W = DELAY_W_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  spike_in,
  input  logic [DELAY_W-1:0]    delay,
  output logic                  spike_out,
  output logic                  busy,
  output logic                  full,
  output logic                  drop,
  output logic [DROP_CNT_W-1:0] drop_count
);

  slot_t                  slots_q [DEPTH];
  slot_t                  slots_d [DEPTH];
  logic                   spike_out_q, spike_out_d;
  logic                   busy_q, busy_d;
  logic                   full_q, full_d;
  logic                   drop_q, drop_d;
  logic [DROP_CNT_W-1:0]  drop_count_q, drop_count_d;
  logic [MAX_DELAY_W-1:0] load_cnt;
  logic                   placed;

  // A slot holds D-1 after the accept edge and fires when its counter is 1,
  // so the registered pulse lands exactly D cycles after the accept cycle.
  always_comb begin
    load_cnt = '0;
    load_cnt[DELAY_W-1:0] = (delay == '0) ? '0 : delay - 1'b1;
    spike_out_d = 1'b0;
    placed      = 1'b0;
    for (int s = 0; s < DEPTH; s++) begin
      slots_d[s] = slots_q[s];
      if (slots_q[s].valid) begin
        if (slots_q[s].counter == '0) begin
          slots_d[s].valid = 1'b0;
        end else begin
          slots_d[s].counter = slots_q[s].counter - 1'b1;
          if (slots_q[s].counter == MAX_DELAY_W'(1)) spike_out_d = 1'b1;
        end
      end
    end
    // Expiring slots are already cleared above, so they are reusable here.
    for (int s = 0; s < DEPTH; s++) begin
      if (spike_in && !placed && !slots_d[s].valid) begin
        slots_d[s].valid   = 1'b1;
        slots_d[s].counter = load_cnt;
        placed             = 1'b1;
      end
    end
    if (placed && load_cnt == '0) spike_out_d = 1'b1;
    drop_d       = spike_in && !placed;
    drop_count_d = drop_count_q;
    if (drop_d && drop_count_q != '1) drop_count_d = drop_count_q + DROP_CNT_W'(1);
    busy_d = 1'b0;
    full_d = 1'b1;
    for (int s = 0; s < DEPTH; s++) begin
      busy_d = busy_d | slots_d[s].valid;
      full_d = full_d & slots_d[s].valid;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < DEPTH; s++) slots_q[s] <= '0;
      spike_out_q  <= 1'b0;
      busy_q       <= 1'b0;
      full_q       <= 1'b0;
      drop_q       <= 1'b0;
      drop_count_q <= '0;
    end else begin
      for (int s = 0; s < DEPTH; s++) slots_q[s] <= slots_d[s];
      spike_out_q  <= spike_out_d;
      busy_q       <= busy_d;
      full_q       <= full_d;
      drop_q       <= drop_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign spike_out  = spike_out_q;
  assign busy       = busy_q;
  assign full       = full_q;
  assign drop       = drop_q;
  assign drop_count = drop_count_q;

endmodule

// File: rtl/axon_delay_line.sv
// Multi-channel axon delay line: CHANNELS fully independent axon_channel
// instances sharing one clock and synchronous reset. DELAY_W must not exceed MAX_DELAY_W.
module axon_delay_line
  import axon_pkg::*;
#(
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int DELAY_W  = DELAY_W_DEF,
  parameter int DEPTH    = DEPTH_DEF
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [CHANNELS-1:0]                   spike_in,
  input  logic [CHANNELS-1:0][DELAY_W-1:0]      delay,
  output logic [CHANNELS-1:0]                   spike_out,
  output logic [CHANNELS-1:0]                   busy,
  output logic [CHANNELS-1:0]                   full,
  output logic [CHANNELS-1:0]                   drop,
  output logic [CHANNELS-1:0][DROP_CNT_W-1:0]   drop_count
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    axon_channel #(
      .DELAY_W (DELAY_W),
      .DEPTH   (DEPTH)
    ) u_ch (
      .clock      (clock),
      .reset      (reset),
      .spike_in   (spike_in[g]),
      .delay      (delay[g]),
      .spike_out  (spike_out[g]),
      .busy       (busy[g]),
      .full       (full[g]),
      .drop       (drop[g]),
      .drop_count (drop_count[g])
    );
  end

endmodule

// File: tb/tb_axon_delay_line.sv
// Bench for axon_delay_line: a release-time model predicts every output cycle,
// expectations are queued by the driver and popped by a negedge monitor.
module tb_axon_delay_line;

  localparam int CH  = 4;
  localparam int DW  = 6;
  localparam int DEP = 4;
  localparam int EW  = 32 + 4 * CH + CH * 8;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [CH-1:0]         spike_in;
  logic [CH-1:0][DW-1:0] delay;
  logic [CH-1:0]         spike_out, busy, full, drop;
  logic [CH-1:0][7:0]    drop_count;

  axon_delay_line #(.CHANNELS(CH), .DELAY_W(DW), .DEPTH(DEP)) dut (
    .clock      (clock),
    .reset      (reset),
    .spike_in   (spike_in),
    .delay      (delay),
    .spike_out  (spike_out),
    .busy       (busy),
    .full       (full),
    .drop       (drop),
    .drop_count (drop_count)
  );

  // clock/reset block
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp_v);
    end
  endfunction

  // reference model: each channel keeps the release cycles of spikes in flight
  int rel_q [CH][$];
  int m_drops [CH];
  logic [EW-1:0] exp_q [$];
  logic [CH-1:0][DW-1:0] dly_v;

  task automatic step(input logic rst, input logic [CH-1:0] spk);
    logic [CH-1:0]      e_so, e_busy, e_full, e_drop;
    logic [CH-1:0][7:0] e_dc;
    reset    = rst;
    spike_in = spk;
    delay    = dly_v;
    e_so = '0; e_busy = '0; e_full = '0; e_drop = '0;
    for (int c = 0; c < CH; c++) begin
      if (rst) begin
        rel_q[c].delete();
        m_drops[c] = 0;
      end else begin
        for (int k = rel_q[c].size() - 1; k >= 0; k--)
          if (rel_q[c][k] <= cyc) rel_q[c].delete(k);
        if (spk[c]) begin
          if (rel_q[c].size() < DEP) begin
            rel_q[c].push_back(cyc + ((dly_v[c] == 0) ? 1 : int'(dly_v[c])));
          end else begin
            e_drop[c] = 1'b1;
            if (m_drops[c] < 255) m_drops[c]++;
          end
        end
        foreach (rel_q[c][k]) if (rel_q[c][k] == cyc + 1) e_so[c] = 1'b1;
        e_busy[c] = rel_q[c].size() > 0;
        e_full[c] = rel_q[c].size() == DEP;
      end
      e_dc[c] = 8'(m_drops[c]);
    end
    exp_q.push_back({32'(cyc + 1), e_so, e_busy, e_full, e_drop, e_dc});
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  task automatic pulse(input int ch);
    logic [CH-1:0] v;
    v = '0;
    v[ch] = 1'b1;
    step(1'b0, v);
  endtask

  // scoreboard monitor
  logic [EW-1:0] mon_e;
  always @(negedge clock) begin
    while (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) < cyc) begin
      mon_e = exp_q.pop_front();
      chk("missed_cycle", 64'(cyc), 64'(mon_e[EW-1 -: 32]));
    end
    if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) == cyc) begin
      mon_e = exp_q.pop_front();
      chk("spike_out",  64'(spike_out),  64'(mon_e[4*CH+8*CH-1 -: CH]));
      chk("busy",       64'(busy),       64'(mon_e[3*CH+8*CH-1 -: CH]));
      chk("full",       64'(full),       64'(mon_e[2*CH+8*CH-1 -: CH]));
      chk("drop",       64'(drop),       64'(mon_e[CH+8*CH-1 -: CH]));
      chk("drop_count", 64'(drop_count), 64'(mon_e[8*CH-1:0]));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  // driver
  initial begin
    for (int c = 0; c < CH; c++) m_drops[c] = 0;
    dly_v = '0;
    step(1'b1, '0);
    step(1'b1, '0);

    // single spike, delay 5
    dly_v[0] = 6'd5;
    idle(10);
    pulse(0);
    idle(8);

    // delay 0 and delay 1 both land one cycle later
    dly_v[0] = 6'd0;
    pulse(0);
    idle(3);
    dly_v[0] = 6'd1;
    pulse(0);
    idle(3);

    // delay change causes two slots to expire together: one merged pulse
    dly_v[2] = 6'd8;
    pulse(2);
    idle(5);
    dly_v[2] = 6'd2;
    pulse(2);
    idle(5);

    // overflow: five spikes into four slots
    dly_v[3] = 6'd20;
    for (int i = 0; i < 5; i++) pulse(3);
    idle(22);

    // full channel, oldest slot expiring is reused in the same cycle
    dly_v[1] = 6'd4;
    for (int i = 0; i < 6; i++) pulse(1);
    idle(6);

    // reset mid-flight discards the pending spike
    dly_v[0] = 6'd5;
    pulse(0);
    idle(1);
    step(1'b1, '0);
    idle(6);

    // drop counter saturation
    dly_v[1] = 6'd63;
    for (int i = 0; i < 340; i++) pulse(1);
    chk("drop_sat", 64'(drop_count[1]), 64'd255);
    step(1'b1, '0);

    // randomized traffic with occasional resets
    for (int n = 0; n < 1500; n++) begin
      logic [CH-1:0] spk;
      for (int c = 0; c < CH; c++) begin
        spk[c]   = ($urandom_range(0, 2) == 0);
        dly_v[c] = ($urandom_range(0, 9) == 0) ? DW'($urandom_range(0, 63))
                                               : DW'($urandom_range(0, 12));
      end
      step(($urandom_range(0, 199) == 0), spk);
    end
    idle(70);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
